// File: rtl/dcache_port_arb.sv
// Data-cache port arbiter: sequences mem-stage loads and writeback-stage
// stores (including two-beat spill stores) onto the single cache port.
module dcache_port_arb #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned AW = 15,
  localparam int unsigned SW = 2,
  localparam int unsigned DW = 32,
  localparam int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [SW-1:0] rd_size,
  output logic          rd_done,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic          wr_spill,
  input  logic [AW-1:0] wr_addr0,
  input  logic [SW-1:0] wr_size0,
  input  logic [DW-1:0] wr_data0,
  input  logic [AW-1:0] wr_addr1,
  input  logic [SW-1:0] wr_size1,
  input  logic [DW-1:0] wr_data1,
  output logic          wr_done,
  input  logic          flush,
  output logic          c_req,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [SW-1:0] c_size,
  output logic [DW-1:0] c_wdata,
  input  logic          c_ready,
  input  logic          c_done,
  input  logic [DW-1:0] c_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR0, S_WR1} state_e;

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic          flushed_q, flushed_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          c_req_q, c_req_d;
  logic          c_we_q, c_we_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [SW-1:0] c_size_q, c_size_d;
  logic [DW-1:0] c_wdata_q, c_wdata_d;
  logic          rd_done_q, rd_done_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          wr_done_q, wr_done_d;
  logic          busy_q, busy_d;

  logic rd_sel, accept, complete;

  assign rd_sel   = rd_req & ~flush;
  assign accept   = c_req_q & c_ready;
  assign complete = c_done & (acc_q | accept);

  // Next-state, cache request and completion pulses.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    flushed_d    = flushed_q;
    starve_cnt_d = starve_cnt_q;
    c_req_d      = c_req_q;
    c_we_d       = c_we_q;
    c_addr_d     = c_addr_q;
    c_size_d     = c_size_q;
    c_wdata_d    = c_wdata_q;
    rd_done_d    = 1'b0;
    rd_data_d    = rd_data_q;
    wr_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_req && !(rd_sel && starve_cnt_q == CW'(STARVE_MAX))) begin
          state_d   = S_WR0;
          c_req_d   = 1'b1;
          c_we_d    = 1'b1;
          c_addr_d  = wr_addr0;
          c_size_d  = wr_size0;
          c_wdata_d = wr_data0;
          if (rd_req && starve_cnt_q < CW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end else if (rd_sel) begin
          state_d      = S_RD;
          c_req_d      = 1'b1;
          c_we_d       = 1'b0;
          c_addr_d     = rd_addr;
          c_size_d     = rd_size;
          starve_cnt_d = '0;
        end
      end
      S_RD: begin
        if (flush) flushed_d = 1'b1;
        if (accept) begin
          c_req_d = 1'b0;
          acc_d   = 1'b1;
        end
        if (complete) begin
          state_d = S_IDLE;
          if (!(flushed_q || flush)) begin
            rd_done_d = 1'b1;
            rd_data_d = c_rdata;
          end
        end else if (flush && !acc_q && !accept) begin
          state_d = S_IDLE;
        end
      end
      S_WR0: begin
        if (accept) begin
          c_req_d = 1'b0;
          acc_d   = 1'b1;
        end
        if (complete) begin
          if (wr_spill) begin
            // Beat 1 follows immediately so no load can slip in between.
            state_d   = S_WR1;
            c_req_d   = 1'b1;
            acc_d     = 1'b0;
            c_addr_d  = wr_addr1;
            c_size_d  = wr_size1;
            c_wdata_d = wr_data1;
          end else begin
            state_d   = S_IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      S_WR1: begin
        if (accept) begin
          c_req_d = 1'b0;
          acc_d   = 1'b1;
        end
        if (complete) begin
          state_d   = S_IDLE;
          wr_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      acc_d     = 1'b0;
      flushed_d = 1'b0;
      c_req_d   = 1'b0;
    end
    if (!rd_req) starve_cnt_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= 1'b0;
      flushed_q    <= 1'b0;
      starve_cnt_q <= '0;
      c_req_q      <= 1'b0;
      c_we_q       <= 1'b0;
      c_addr_q     <= '0;
      c_size_q     <= '0;
      c_wdata_q    <= '0;
      rd_done_q    <= 1'b0;
      rd_data_q    <= '0;
      wr_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      flushed_q    <= flushed_d;
      starve_cnt_q <= starve_cnt_d;
      c_req_q      <= c_req_d;
      c_we_q       <= c_we_d;
      c_addr_q     <= c_addr_d;
      c_size_q     <= c_size_d;
      c_wdata_q    <= c_wdata_d;
      rd_done_q    <= rd_done_d;
      rd_data_q    <= rd_data_d;
      wr_done_q    <= wr_done_d;
      busy_q       <= busy_d;
    end
  end

  assign c_req   = c_req_q;
  assign c_we    = c_we_q;
  assign c_addr  = c_addr_q;
  assign c_size  = c_size_q;
  assign c_wdata = c_wdata_q;
  assign rd_done = rd_done_q;
  assign rd_data = rd_data_q;
  assign wr_done = wr_done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Scoreboard bench for dcache_port_arb with a behavioural cache model.
module tb_dcache_port_arb;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0, wr_spill = 1'b0, flush = 1'b0;
  logic [14:0] rd_addr = '0, wr_addr0 = '0, wr_addr1 = '0;
  logic [1:0]  rd_size = '0, wr_size0 = '0, wr_size1 = '0;
  logic [31:0] wr_data0 = '0, wr_data1 = '0;
  logic        rd_done, wr_done, c_req, c_we, busy;
  logic [31:0] rd_data, c_wdata;
  logic [14:0] c_addr;
  logic [1:0]  c_size;
  logic        c_ready = 1'b0, c_done = 1'b0;
  logic [31:0] c_rdata = '0;

  dcache_port_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_spill(wr_spill),
    .wr_addr0(wr_addr0), .wr_size0(wr_size0), .wr_data0(wr_data0),
    .wr_addr1(wr_addr1), .wr_size1(wr_size1), .wr_data1(wr_data1),
    .wr_done(wr_done), .flush(flush),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_done(c_done), .c_rdata(c_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_bad = 0;
  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  int          exp_wr = 0;
  int          acc_cnt = 0, stall_cnt = 0;
  bit          wr_outstanding = 1'b0, prev_stall = 1'b0;
  logic [14:0] prev_addr;
  logic [1:0]  prev_size;
  logic        prev_we;
  logic [31:0] last_rd = '0;

  // cache model knobs
  int          m_bp = 0, m_lat = 1, cd_cnt = 0;
  logic [31:0] m_rdata = '0;
  bit          neg_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [14:0] a, input logic [1:0] s, input logic [31:0] d);
    req_t e;
    e.we = we; e.addr = a; e.size = s; e.wdata = d;
    exp_req.push_back(e);
  endtask

  // Cache model: backpressure for m_bp request cycles, c_done m_lat cycles after accept.
  always @(posedge clk) begin
    #1;
    c_done = 1'b0;
    if (rst) begin
      cd_cnt  = 0;
      c_ready = 1'b0;
    end else begin
      if (neg_acc) begin
        if (m_lat >= 1) begin
          cd_cnt = m_lat - 1;
          if (cd_cnt == 0) c_done = 1'b1;
        end
      end else if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) c_done = 1'b1;
      end
      c_ready = 1'b0;
      if (c_req) begin
        if (m_bp > 0) m_bp--;
        else begin
          c_ready = 1'b1;
          if (m_lat == 0) c_done = 1'b1;
        end
      end
      if (c_done) c_rdata = m_rdata;
    end
  end

  // Monitor: compares accepted accesses and completions against the scoreboard.
  always @(negedge clk) begin
    req_t e;
    neg_acc = c_req & c_ready;
    if (rst) begin
      wr_outstanding = 1'b0;
      prev_stall     = 1'b0;
    end else begin
      if (c_req && prev_stall) begin
        chk("hold_addr", 64'(c_addr), 64'(prev_addr));
        chk("hold_size", 64'(c_size), 64'(prev_size));
        chk("hold_we", 64'(c_we), 64'(prev_we));
      end
      if (c_req && c_ready) begin
        acc_cnt++;
        if (exp_req.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_access: got addr %0h we %0b expected none", c_addr, c_we);
        end else begin
          e = exp_req.pop_front();
          chk("acc_we", 64'(c_we), 64'(e.we));
          chk("acc_addr", 64'(c_addr), 64'(e.addr));
          chk("acc_size", 64'(c_size), 64'(e.size));
          if (e.we) chk("acc_wdata", 64'(c_wdata), 64'(e.wdata));
        end
        if (c_we) wr_outstanding = 1'b1;
      end
      if (c_req && !c_ready) stall_cnt++;
      prev_stall = c_req && !c_ready;
      prev_addr  = c_addr;
      prev_size  = c_size;
      prev_we    = c_we;
      if (rd_done) begin
        if (exp_rd.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_rd_done: got data %0h expected no pulse", rd_data);
        end else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
      end
      if (wr_done) begin
        n_vec++;
        if (exp_wr == 0) begin
          n_bad++;
          $display("FAIL unexpected_wr_done: got pulse expected none");
        end else exp_wr--;
        wr_outstanding = 1'b0;
      end
      assert (!(wr_outstanding && !wr_req))
      else begin
        n_bad++;
        $error("FAIL wr_req_protocol: got wr_req 0 expected 1 until wr_done");
      end
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Drive until both requests are retired; keep_wr re-issues stores back to back.
  task automatic run(input string name, input int budget, input bit keep_wr);
    int n = 0;
    while ((rd_req || wr_req) && n < budget) begin
      @(posedge clk); #1; n++;
      if (wr_done && !keep_wr) wr_req = 1'b0;
      if (rd_done) begin
        rd_req = 1'b0;
        if (keep_wr) wr_req = 1'b0;
      end
    end
    chk({name, "_retired"}, 64'(rd_req | wr_req), 64'd0);
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_req.size() != 0 || exp_rd.size() != 0 || exp_wr != 0 || busy) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({name, "_drained"}, 64'(exp_req.size() + exp_rd.size() + exp_wr + int'(busy)), 64'd0);
    align();
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_accept_seen"}, 64'(acc_cnt >= target), 64'd1);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {c_req, c_we, c_addr, c_size, rd_done, wr_done, busy}, 64'd0);
    chk({name, "_data"}, {c_wdata, rd_data}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    align();

    // Load only
    m_bp = 0; m_lat = 2; m_rdata = 32'hDEADBEEF;
    rd_addr = 15'h0123; rd_size = 2'd3; rd_req = 1'b1;
    push_req(1'b0, 15'h0123, 2'd3, '0);
    exp_rd.push_back(32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    chk("load_creq_rise", 64'(c_req), 64'd1);
    chk("load_cwe", 64'(c_we), 64'd0);
    chk("load_caddr", 64'(c_addr), 64'h0123);
    run("load", 50, 1'b0);
    drain("load", 50);
    last_rd = 32'hDEADBEEF;

    // Ready backpressure for 5 cycles
    stall_cnt = 0; m_bp = 5; m_lat = 1; m_rdata = 32'h0BADF00D;
    rd_addr = 15'h7ABC; rd_size = 2'd2; rd_req = 1'b1;
    push_req(1'b0, 15'h7ABC, 2'd2, '0);
    exp_rd.push_back(32'h0BADF00D);
    run("bp", 50, 1'b0);
    drain("bp", 50);
    chk("bp_stall_cycles", 64'(stall_cnt), 64'd5);
    last_rd = 32'h0BADF00D;

    // Store accepted and completed in the same cycle
    m_bp = 0; m_lat = 0;
    wr_spill = 1'b0; wr_addr0 = 15'h0055; wr_size0 = 2'd0; wr_data0 = 32'h000000A5;
    wr_req = 1'b1;
    push_req(1'b1, 15'h0055, 2'd0, 32'h000000A5);
    exp_wr++;
    run("same_cycle", 50, 1'b0);
    drain("same_cycle", 50);

    // Spill store with a concurrent load
    m_bp = 0; m_lat = 2; m_rdata = 32'h13572468;
    wr_spill = 1'b1;
    wr_addr0 = 15'h0FFE; wr_size0 = 2'd1; wr_data0 = 32'h1111AAAA;
    wr_addr1 = 15'h1000; wr_size1 = 2'd1; wr_data1 = 32'h2222BBBB;
    rd_addr = 15'h0200; rd_size = 2'd3;
    wr_req = 1'b1; rd_req = 1'b1;
    push_req(1'b1, 15'h0FFE, 2'd1, 32'h1111AAAA);
    push_req(1'b1, 15'h1000, 2'd1, 32'h2222BBBB);
    push_req(1'b0, 15'h0200, 2'd3, '0);
    exp_wr++;
    exp_rd.push_back(32'h13572468);
    run("spill", 80, 1'b0);
    drain("spill", 50);
    last_rd = 32'h13572468;

    // Starvation bound: 4 stores, then the waiting load
    m_bp = 0; m_lat = 1; m_rdata = 32'h24681357;
    wr_spill = 1'b0; wr_addr0 = 15'h0300; wr_size0 = 2'd2; wr_data0 = 32'hCAFE0001;
    rd_addr = 15'h0400; rd_size = 2'd3;
    for (int i = 0; i < 4; i++) push_req(1'b1, 15'h0300, 2'd2, 32'hCAFE0001);
    push_req(1'b0, 15'h0400, 2'd3, '0);
    exp_wr += 4;
    exp_rd.push_back(32'h24681357);
    wr_req = 1'b1; rd_req = 1'b1;
    run("starve", 120, 1'b1);
    drain("starve", 50);
    chk("starve_cnt_cleared", 64'(dut.starve_cnt_q), 64'd0);
    last_rd = 32'h24681357;

    // Flush before accept
    base = acc_cnt;
    m_bp = 3; m_lat = 1; m_rdata = 32'h55555555;
    rd_addr = 15'h0500; rd_size = 2'd1; rd_req = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1; rd_req = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_pre_creq", 64'(c_req), 64'd0);
    chk("flush_pre_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("flush_pre_no_access", 64'(acc_cnt - base), 64'd0);
    m_bp = 0;
    drain("flush_pre", 20);

    // Flush after accept
    base = acc_cnt;
    m_bp = 0; m_lat = 3; m_rdata = 32'h99998888;
    rd_addr = 15'h0600; rd_size = 2'd3; rd_req = 1'b1;
    push_req(1'b0, 15'h0600, 2'd3, '0);
    wait_acc("flush_post", base + 1, 20);
    flush = 1'b1; rd_req = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    drain("flush_post", 30);
    chk("flush_post_rd_data", 64'(rd_data), 64'(last_rd));

    // Flush during WR0
    m_bp = 2; m_lat = 2;
    wr_spill = 1'b0; wr_addr0 = 15'h0700; wr_size0 = 2'd3; wr_data0 = 32'h0F0F0F0F;
    wr_req = 1'b1;
    push_req(1'b1, 15'h0700, 2'd3, 32'h0F0F0F0F);
    exp_wr++;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    run("flush_wr", 50, 1'b0);
    drain("flush_wr", 50);

    // Reset mid-WR1, store re-selected from beat 0
    base = acc_cnt;
    m_bp = 0; m_lat = 4;
    wr_spill = 1'b1;
    wr_addr0 = 15'h0800; wr_size0 = 2'd2; wr_data0 = 32'h01234567;
    wr_addr1 = 15'h0A00; wr_size1 = 2'd0; wr_data1 = 32'h89ABCDEF;
    push_req(1'b1, 15'h0800, 2'd2, 32'h01234567);
    push_req(1'b1, 15'h0A00, 2'd0, 32'h89ABCDEF);
    push_req(1'b1, 15'h0800, 2'd2, 32'h01234567);
    push_req(1'b1, 15'h0A00, 2'd0, 32'h89ABCDEF);
    exp_wr++;
    wr_req = 1'b1;
    wait_acc("rst_wr1", base + 2, 40);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid_wr1");
    rst = 1'b0;
    align();
    run("rst_retry", 80, 1'b0);
    drain("rst_retry", 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
